// File: rtl/ram_alu_pkg.sv
// Shared definitions for the RAM_ALU front-end sequencer,
// the RAM_ALU datapath and their benches.
package ram_alu_pkg;

  localparam logic [1:0] OP_SQDIFF  = 2'd0;
  localparam logic [1:0] OP_MOD     = 2'd1;
  localparam logic [1:0] OP_DIV     = 2'd2;
  localparam logic [1:0] OP_MODDIFF = 2'd3;

  localparam logic [1:0] ADDR_X   = 2'd0;
  localparam logic [1:0] ADDR_Y   = 2'd1;
  localparam logic [1:0] ADDR_RES = 2'd2;

  localparam int RDCNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_X = 3'd1,
    S_WR_Y = 3'd2,
    S_RD   = 3'd3,
    S_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/ram_alu_seq_fsm.sv
// State register and read-wait counter of the RAM_ALU sequencer.
// Exposes next state so the top can register Moore outputs in step.
module ram_alu_seq_fsm
  import ram_alu_pkg::*;
#(
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic       err,
  input  logic       rsp_ready,
  output seq_state_t state,
  output seq_state_t nxt,
  output logic       rd_last
);

  logic [RDCNT_W-1:0] rd_cnt;

  assign rd_last = (state == S_RD) &&
                   (rd_cnt == RDCNT_W'(RD_WAIT - 1));

  // Next-state selection; an operand error skips the ALU entirely
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (accept) nxt = err ? S_DONE : S_WR_X;
      S_WR_X:  nxt = S_WR_Y;
      S_WR_Y:  nxt = S_RD;
      S_RD:    if (rd_last) nxt = S_DONE;
      S_DONE:  if (rsp_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // State register and RD dwell counter, cleared outside RD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rd_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_RD && !rd_last)
        rd_cnt <= rd_cnt + RDCNT_W'(1);
      else
        rd_cnt <= '0;
    end
  end

endmodule

// File: rtl/ram_alu_sequencer.sv
// Front-end controller driving RAM_ALU: write X, write Y, read result.
// Optional operand check under macro RAM_ALU_SEQ_ERRCHK_EN.
module ram_alu_sequencer
  import ram_alu_pkg::*;
#(
  parameter int DW      = 16,
  parameter int RW      = 32,
  parameter int RD_WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_x,
  input  logic [DW-1:0] req_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          alu_e,
  output logic [1:0]    alu_op,
  output logic [1:0]    alu_addr,
  output logic [DW-1:0] alu_din,
  output logic          alu_w,
  output logic          alu_r,
  input  logic [RW-1:0] alu_dout,
  output logic [15:0]   jobs_done
);

  seq_state_t    state;
  seq_state_t    nxt;
  logic          rd_last;
  logic          accept;
  logic          chk_err;
  logic [DW-1:0] y_q;

  assign accept = req_valid & req_ready;

`ifdef RAM_ALU_SEQ_ERRCHK_EN
  assign chk_err =
    ((req_op == OP_MOD || req_op == OP_DIV) && req_y == '0) ||
    (req_op == OP_MODDIFF && req_x == req_y);
`else
  assign chk_err = 1'b0;
`endif

  ram_alu_seq_fsm #(
    .RD_WAIT(RD_WAIT)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .err      (chk_err),
    .rsp_ready(rsp_ready),
    .state    (state),
    .nxt      (nxt),
    .rd_last  (rd_last)
  );

  // Moore outputs registered from next state; job latched on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_e     <= 1'b0;
      alu_w     <= 1'b0;
      alu_r     <= 1'b0;
      alu_op    <= '0;
      alu_addr  <= ADDR_X;
      alu_din   <= '0;
      y_q       <= '0;
      jobs_done <= '0;
    end else begin
      req_ready <= (nxt == S_IDLE);
      rsp_valid <= (nxt == S_DONE);
      alu_e     <= nxt inside {S_WR_X, S_WR_Y, S_RD};
      alu_w     <= nxt inside {S_WR_X, S_WR_Y};
      alu_r     <= (nxt == S_RD);
      unique case (1'b1)
        nxt == S_WR_X: begin
          alu_addr <= ADDR_X;
          alu_din  <= req_x;
        end
        nxt == S_WR_Y: begin
          alu_addr <= ADDR_Y;
          alu_din  <= y_q;
        end
        nxt == S_RD: begin
          alu_addr <= ADDR_RES;
          alu_din  <= '0;
        end
        default: begin
          alu_addr <= ADDR_X;
          alu_din  <= '0;
        end
      endcase
      if (accept) begin
        alu_op  <= req_op;
        y_q     <= req_y;
        rsp_err <= chk_err;
        if (chk_err)
          rsp_data <= '0;
      end
      if (rd_last)
        rsp_data <= alu_dout;
      if (state == S_DONE && rsp_ready &&
          jobs_done != 16'hFFFF)
        jobs_done <= jobs_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_alu_sequencer.sv
// Directed bench for ram_alu_sequencer with a behavioural RAM_ALU.
// Build with +define+RAM_ALU_SEQ_ERRCHK_EN to cover the error path.
module tb_ram_alu_sequencer;

  localparam int RD_WAIT = 2;
  localparam int LAT     = RD_WAIT + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [15:0] req_x = 16'd0;
  logic [15:0] req_y = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        alu_e;
  logic [1:0]  alu_op;
  logic [1:0]  alu_addr;
  logic [15:0] alu_din;
  logic        alu_w;
  logic        alu_r;
  logic [31:0] alu_dout;
  logic [15:0] jobs_done;

  int n_chk  = 0;
  int n_fail = 0;

  ram_alu_sequencer #(
    .DW(16), .RW(32), .RD_WAIT(RD_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_e(alu_e), .alu_op(alu_op), .alu_addr(alu_addr),
    .alu_din(alu_din), .alu_w(alu_w), .alu_r(alu_r),
    .alu_dout(alu_dout), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Behavioural RAM_ALU plus write/read/overlap logging
  logic [15:0] mx = 16'd0;
  logic [15:0] my = 16'd0;
  logic [1:0]  wr_a [0:63];
  logic [15:0] wr_d [0:63];
  int          wr_n = 0;
  int          rd_n = 0;
  int          both_n = 0;

  function automatic logic [31:0] calc(
    input logic [1:0] op, input logic [15:0] x, y);
    logic [31:0] a, b, d;
    a = {16'd0, x};
    b = {16'd0, y};
    d = a - b;
    case (op)
      2'd0: calc = (a + b) * d;
      2'd1: calc = (b == 0) ? 32'hFFFF_FFFF : a % b;
      2'd2: calc = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: calc = (d == 0) ? 32'hFFFF_FFFF : a % d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_e && alu_w) begin
      if (alu_addr == 2'd0) mx <= alu_din;
      if (alu_addr == 2'd1) my <= alu_din;
      wr_a[wr_n % 64] <= alu_addr;
      wr_d[wr_n % 64] <= alu_din;
      wr_n <= wr_n + 1;
    end
    if (alu_e && alu_r && alu_addr == 2'd2) rd_n <= rd_n + 1;
    if (alu_w && alu_r) both_n <= both_n + 1;
  end

  assign alu_dout = (alu_e && alu_r && alu_addr == 2'd2) ?
                    calc(alu_op, mx, my) : 32'd0;

  task automatic send(input logic [1:0] op,
                      input logic [15:0] x, y);
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // cyc = cycle index after the accept edge in which rsp_valid is seen
  task automatic wait_rsp(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  localparam logic [73:0] RST_VEC =
    {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
     2'd0, 16'd0, 2'd0, 32'd0, 16'd0};

  function automatic logic [73:0] out_vec();
    return {req_ready, rsp_valid, rsp_err, alu_e, alu_w, alu_r,
            alu_addr, alu_din, alu_op, rsp_data, jobs_done};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (out_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_vals got=%h exp=%h", out_vec(), RST_VEC);
    end
  endtask

  task automatic test_single();
    int cyc, b, r;
    rsp_ready = 1'b1;
    b = wr_n; r = rd_n;
    send(2'd0, 16'd445, 16'd100);
    wait_rsp(cyc);
    n_chk++;
    if (cyc !== LAT) begin
      n_fail++; $display("FAIL t1_latency got=%0d exp=%0d", cyc, LAT);
    end
    n_chk++;
    if (rsp_data !== 32'd188025 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_data got=%0d/%b exp=188025/0", rsp_data, rsp_err);
    end
    n_chk++;
    if (wr_n - b !== 2) begin
      n_fail++; $display("FAIL t1_wr_count got=%0d exp=2", wr_n - b);
    end
    n_chk++;
    if (wr_a[b % 64] !== 2'd0 || wr_d[b % 64] !== 16'd445) begin
      n_fail++;
      $display("FAIL t1_wr_x got=%0d/%0d exp=0/445",
               wr_a[b % 64], wr_d[b % 64]);
    end
    n_chk++;
    if (wr_a[(b + 1) % 64] !== 2'd1 ||
        wr_d[(b + 1) % 64] !== 16'd100) begin
      n_fail++;
      $display("FAIL t1_wr_y got=%0d/%0d exp=1/100",
               wr_a[(b + 1) % 64], wr_d[(b + 1) % 64]);
    end
    n_chk++;
    if (rd_n - r !== RD_WAIT) begin
      n_fail++;
      $display("FAIL t1_rd_cycles got=%0d exp=%0d", rd_n - r, RD_WAIT);
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
        jobs_done !== 16'd1) begin
      n_fail++;
      $display("FAIL t1_idle got=%b/%b/%0d exp=0/1/1",
               rsp_valid, req_ready, jobs_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] exp [3] = '{32'd45, 32'd4, 32'd100};
    int bad, cyc, j0;
    rsp_ready = 1'b1;
    bad = 0;
    j0 = int'(jobs_done);
    for (int k = 0; k < 3; k++) begin
      send(ops[k], 16'd445, 16'd100);
      cyc = -1;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (req_ready) bad++;
        if (rsp_valid) begin
          cyc = i;
          break;
        end
      end
      n_chk++;
      if (cyc !== LAT || rsp_data !== exp[k]) begin
        n_fail++;
        $display("FAIL t2_job%0d got=%0d@%0d exp=%0d@%0d",
                 k, rsp_data, cyc, exp[k], LAT);
      end
      @(posedge clk);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL t2_req_ready_busy got=%0d exp=0", bad);
    end
    @(negedge clk);
    n_chk++;
    if (int'(jobs_done) - j0 !== 3) begin
      n_fail++;
      $display("FAIL t2_jobs_done got=%0d exp=3", int'(jobs_done) - j0);
    end
  endtask

  task automatic test_backpressure();
    int cyc, bad, b;
    logic [15:0] j0;
    rsp_ready = 1'b0;
    send(2'd1, 16'd445, 16'd100);
    wait_rsp(cyc);
    n_chk++;
    if (cyc !== LAT) begin
      n_fail++; $display("FAIL t3_latency got=%0d exp=%0d", cyc, LAT);
    end
    j0 = jobs_done;
    b = wr_n;
    req_op = 2'd0; req_x = 16'd7; req_y = 16'd3; req_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 32'd45 || req_ready) bad++;
    end
    n_chk++;
    if (bad !== 0 || wr_n !== b || jobs_done !== j0) begin
      n_fail++;
      $display("FAIL t3_hold got=bad%0d/wr%0d/jd%0d exp=0/%0d/%0d",
               bad, wr_n, jobs_done, b, j0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0 || jobs_done !== j0 + 16'd1) begin
      n_fail++;
      $display("FAIL t3_release got=%b/%0d exp=0/%0d",
               rsp_valid, jobs_done, j0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid_job();
    int cyc, bad;
    rsp_ready = 1'b1;
    send(2'd0, 16'd445, 16'd100);
    repeat (3) @(negedge clk);
    n_chk++;
    if (alu_r !== 1'b1 || alu_addr !== 2'd2) begin
      n_fail++;
      $display("FAIL t4_in_rd got=%b/%0d exp=1/2", alu_r, alu_addr);
    end
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (out_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL t4_async_rst got=%h exp=%h", out_vec(), RST_VEC);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL t4_no_rsp got=%0d exp=0", bad);
    end
    send(2'd3, 16'd445, 16'd100);
    wait_rsp(cyc);
    n_chk++;
    if (cyc !== LAT || rsp_data !== 32'd100) begin
      n_fail++;
      $display("FAIL t4_next_job got=%0d@%0d exp=100@%0d",
               rsp_data, cyc, LAT);
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (jobs_done !== 16'd1) begin
      n_fail++; $display("FAIL t4_jobs_done got=%0d exp=1", jobs_done);
    end
  endtask

  task automatic test_errchk();
    int cyc, b, r;
    rsp_ready = 1'b1;
    b = wr_n; r = rd_n;
    send(2'd2, 16'd445, 16'd0);
    wait_rsp(cyc);
`ifdef RAM_ALU_SEQ_ERRCHK_EN
    n_chk++;
    if (cyc !== 1 || rsp_err !== 1'b1 || rsp_data !== 32'd0) begin
      n_fail++;
      $display("FAIL t5_err got=%0d/%b/%0d exp=1/1/0",
               cyc, rsp_err, rsp_data);
    end
    n_chk++;
    if (wr_n !== b || rd_n !== r) begin
      n_fail++;
      $display("FAIL t5_no_alu got=%0d/%0d exp=%0d/%0d",
               wr_n, rd_n, b, r);
    end
`else
    n_chk++;
    if (cyc !== LAT || rsp_err !== 1'b0 ||
        rsp_data !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL t5_noerr got=%0d/%b/%h exp=%0d/0/ffffffff",
               cyc, rsp_err, rsp_data, LAT);
    end
    n_chk++;
    if (wr_n - b !== 2 || rd_n - r !== RD_WAIT) begin
      n_fail++;
      $display("FAIL t5_alu_ran got=%0d/%0d exp=2/%0d",
               wr_n - b, rd_n - r, RD_WAIT);
    end
`endif
    @(posedge clk);
  endtask

  task automatic test_saturation();
    int cyc;
    rsp_ready = 1'b1;
    @(negedge clk);
    force dut.jobs_done = 16'hFFFE;
    #1 release dut.jobs_done;
    for (int k = 0; k < 3; k++) begin
      send(2'd2, 16'd445, 16'd100);
      wait_rsp(cyc);
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (jobs_done !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL t6_sat_job%0d got=%h exp=ffff", k, jobs_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_job();
    test_errchk();
    test_saturation();
    n_chk++;
    if (both_n !== 0) begin
      n_fail++; $display("FAIL w_r_overlap got=%0d exp=0", both_n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
